fifo_stream_ctrl: RTL and testbench

//  Next-generation first-word fall-through (FWFT) stream FIFO. Replaces the fixed-mode

---
 rtl/fifo_stream_ctrl.sv | 149 ++++++++++++++
 tb/tb_fifo_stream_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_ctrl.sv
// rtl/fifo_stream_ctrl.sv - first-word fall-through stream FIFO with flush and optional packet mode
//
// Purpose:
//   Register-array FWFT FIFO of any DEPTH (2..2**ADDR_WIDTH). It provides an occupancy
//   count, almost-full/almost-empty flags decoded from the registered count, and a
//   synchronous flush. When the macro FIFO_STREAM_PKT_EN is defined, the head word is
//   withheld until a complete packet (TLAST) is stored. A completely full FIFO is always
//   released, so a packet larger than the FIFO cuts through instead of deadlocking.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   flush                 synchronous clear of pointers, count and packet count
//   din_TVALID/TREADY     write handshake; din_TDATA carries the payload
//   din_TLAST             end of packet on write (FIFO_STREAM_PKT_EN only)
//   dout_TVALID/TREADY    read handshake; dout_TDATA is the head word (FWFT)
//   dout_TLAST            head word ends a packet (FIFO_STREAM_PKT_EN only)
//   count                 stored words, 0..DEPTH
//   almost_full           count >= AF_THRESH
//   almost_empty          count <= AE_THRESH
module fifo_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int AF_THRESH  = 30,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  din_TVALID,
  output logic                  din_TREADY,
  input  logic [DATA_WIDTH-1:0] din_TDATA,
`ifdef FIFO_STREAM_PKT_EN
  input  logic                  din_TLAST,
`endif
  output logic                  dout_TVALID,
  input  logic                  dout_TREADY,
  output logic [DATA_WIDTH-1:0] dout_TDATA,
`ifdef FIFO_STREAM_PKT_EN
  output logic                  dout_TLAST,
`endif
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

`ifdef FIFO_STREAM_PKT_EN
  localparam int ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic                  init;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head;

  // Explicit wrap compare: DEPTH need not be a power of two.
  assign wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

  // No pass-through when full: a pop in the same cycle does not reopen the input.
  assign din_TREADY = init & (count != FULL_CNT);
  assign push       = din_TVALID & din_TREADY;
  assign pop        = dout_TVALID & dout_TREADY;

  assign head       = mem[rd_ptr];
  assign dout_TDATA = head[DATA_WIDTH-1:0];

  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

`ifdef FIFO_STREAM_PKT_EN
  logic [ADDR_WIDTH:0] pkt_cnt;
  logic                push_last;
  logic                pop_last;

  assign wr_entry    = {din_TLAST, din_TDATA};
  assign dout_TLAST  = head[DATA_WIDTH];
  assign push_last   = push & din_TLAST;
  assign pop_last    = pop & head[DATA_WIDTH];
  // Full with no complete packet: release anyway so oversize packets cut through.
  assign dout_TVALID = (count != '0) & ((pkt_cnt != '0) | (count == FULL_CNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (flush) begin
      pkt_cnt <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`else
  assign wr_entry    = din_TDATA;
  assign dout_TVALID = (count != '0);
`endif

  // Storage has no reset; flush only discards pointers, so old contents remain.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      init   <= 1'b0;
    end else begin
      init <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr_nxt;
        end
        if (pop) begin
          rd_ptr <= rd_ptr_nxt;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb/tb_fifo_stream_ctrl.sv - directed bench with a queue-level reference model for fifo_stream_ctrl
module tb_fifo_stream_ctrl;

`ifdef FIFO_STREAM_PKT_EN
  localparam bit PKT  = 1'b1;
  localparam int NDUT = 3;
`else
  localparam bit PKT  = 1'b0;
  localparam int NDUT = 2;
`endif

  // Instance 0: DEPTH 32, instance 1: DEPTH 5, instance 2 (packet build): DEPTH 8.
  localparam int DEP [3] = '{32, 5, 8};
  localparam int AFT [3] = '{30, 4, 7};
  localparam int AET [3] = '{2, 1, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid [3];
  logic [31:0] in_data  [3];
  logic        in_last  [3];
  logic        out_ready[3];
  logic        o_ready  [3];
  logic        o_valid  [3];
  logic [31:0] o_data   [3];
  logic        o_last   [3];
  logic        o_af     [3];
  logic        o_ae     [3];
  logic [5:0]  c0;
  logic [3:0]  c1;
  logic [3:0]  c2;
  int          o_count  [3];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32), .AF_THRESH(30), .AE_THRESH(2)) u_d32 (
    .clk(clk), .reset(reset), .flush(flush),
    .din_TVALID(in_valid[0]), .din_TREADY(o_ready[0]), .din_TDATA(in_data[0]),
`ifdef FIFO_STREAM_PKT_EN
    .din_TLAST(in_last[0]), .dout_TLAST(o_last[0]),
`endif
    .dout_TVALID(o_valid[0]), .dout_TREADY(out_ready[0]), .dout_TDATA(o_data[0]),
    .count(c0), .almost_full(o_af[0]), .almost_empty(o_ae[0])
  );

  fifo_stream_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
    .clk(clk), .reset(reset), .flush(flush),
    .din_TVALID(in_valid[1]), .din_TREADY(o_ready[1]), .din_TDATA(in_data[1]),
`ifdef FIFO_STREAM_PKT_EN
    .din_TLAST(in_last[1]), .dout_TLAST(o_last[1]),
`endif
    .dout_TVALID(o_valid[1]), .dout_TREADY(out_ready[1]), .dout_TDATA(o_data[1]),
    .count(c1), .almost_full(o_af[1]), .almost_empty(o_ae[1])
  );

`ifdef FIFO_STREAM_PKT_EN
  fifo_stream_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1)) u_d8 (
    .clk(clk), .reset(reset), .flush(flush),
    .din_TVALID(in_valid[2]), .din_TREADY(o_ready[2]), .din_TDATA(in_data[2]),
    .din_TLAST(in_last[2]), .dout_TLAST(o_last[2]),
    .dout_TVALID(o_valid[2]), .dout_TREADY(out_ready[2]), .dout_TDATA(o_data[2]),
    .count(c2), .almost_full(o_af[2]), .almost_empty(o_ae[2])
  );
`else
  assign c2 = '0;
  assign o_ready[2] = 1'b0;
  assign o_valid[2] = 1'b0;
  assign o_data[2]  = '0;
  assign o_af[2]    = 1'b0;
  assign o_ae[2]    = 1'b1;
  assign o_last[0]  = 1'b0;
  assign o_last[1]  = 1'b0;
`endif
`ifdef FIFO_STREAM_PKT_EN
`else
  assign o_last[2] = 1'b0;
`endif

  always_comb begin
    o_count[0] = int'(c0);
    o_count[1] = int'(c1);
    o_count[2] = int'(c2);
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is an ordered list of {last, data}, entry 0 is the head.
  logic [32:0] mq [3][64];
  int          msize [3];
  bit          minit [3];

  function automatic int m_pkts(input int d);
    int n = 0;
    for (int i = 0; i < msize[d]; i++) n += int'(mq[d][i][32]);
    return n;
  endfunction

  function automatic bit m_ready(input int d);
    return minit[d] && (msize[d] != DEP[d]);
  endfunction

  function automatic bit m_valid(input int d);
    if (msize[d] == 0) return 1'b0;
    if (!PKT) return 1'b1;
    return (m_pkts(d) > 0) || (msize[d] == DEP[d]);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        msize[d] = 0;
        minit[d] = 1'b0;
      end else begin
        automatic bit pu = in_valid[d] && m_ready(d);
        automatic bit po = m_valid(d) && out_ready[d];
        if (flush) begin
          msize[d] = 0;
        end else begin
          if (po) begin
            for (int i = 0; i < 63; i++) mq[d][i] = mq[d][i+1];
            msize[d]--;
          end
          if (pu) begin
            mq[d][msize[d]] = {in_last[d], in_data[d]};
            msize[d]++;
          end
        end
        minit[d] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        if (reset) begin
          check($sformatf("rst_count%0d", d), o_count[d], 0);
          check($sformatf("rst_ready%0d", d), o_ready[d], 0);
          check($sformatf("rst_valid%0d", d), o_valid[d], 0);
          check($sformatf("rst_af%0d", d), o_af[d], 0);
          check($sformatf("rst_ae%0d", d), o_ae[d], 1);
        end else begin
          check($sformatf("count%0d", d), o_count[d], msize[d]);
          check($sformatf("ready%0d", d), o_ready[d], m_ready(d));
          check($sformatf("valid%0d", d), o_valid[d], m_valid(d));
          check($sformatf("af%0d", d), o_af[d], msize[d] >= AFT[d]);
          check($sformatf("ae%0d", d), o_ae[d], msize[d] <= AET[d]);
          if (m_valid(d)) begin
            check($sformatf("data%0d", d), o_data[d], mq[d][0][31:0]);
            if (PKT) check($sformatf("last%0d", d), o_last[d], mq[d][0][32]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nin;
    int nout;
    int cyc;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b0;
      msize[d] = 0; minit[d] = 1'b0;
    end
    #1 reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("t0_count", o_count[0], 0);
    check("t0_ready", o_ready[0], 0);
    check("t0_ae", o_ae[0], 1);
    reset = 1'b0;
    tick();
    check("t0_ready_after_init", o_ready[0], 1);

    // Fill the 32-deep FIFO with 0x01..0x20 while the consumer stalls.
    for (int i = 1; i <= 32; i++) begin
      in_valid[0] = 1'b1; in_data[0] = i;
      tick();
      check($sformatf("t1_count_%0d", i), o_count[0], i);
      check($sformatf("t1_af_%0d", i), o_af[0], i >= 30);
    end
    check("t1_full_ready", o_ready[0], 0);
    check("t1_head", o_data[0], 32'h01);

    // Full: one-cycle pop, the offered word is refused that cycle and taken the next.
    in_data[0] = 32'h21; out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("t2_count_after_pop", o_count[0], 31);
    check("t2_head_after_pop", o_data[0], 32'h02);
    tick();
    in_valid[0] = 1'b0;
    check("t2_count_refill", o_count[0], 32);
    out_ready[0] = 1'b1;
    nout = 2;
    for (cyc = 0; cyc < 40 && nout <= 32'h21; cyc++) begin
      if (o_valid[0]) begin
        check("t2_drain", o_data[0], nout);
        nout++;
      end
      tick();
    end
    out_ready[0] = 1'b0;
    check("t2_drain_done", nout, 32'h22);
    check("t2_empty", o_valid[0], 0);

    // DEPTH 5: 100 incrementing words streamed with periodic consumer stalls.
    nin = 0; nout = 0;
    for (cyc = 0; cyc < 1000 && nout < 100; cyc++) begin
      automatic bit acc_in;
      in_valid[1] = (nin < 100);
      in_data[1] = nin;
      out_ready[1] = (cyc % 7) < 4;
      acc_in = in_valid[1] && o_ready[1];
      if (o_valid[1] && out_ready[1]) begin
        check("t3_order", o_data[1], nout);
        nout++;
      end
      if (o_count[1] > 5) check("t3_count_range", o_count[1], 5);
      tick();
      if (acc_in) nin++;
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    check("t3_all_out", nout, 100);

    // Flush with a concurrent push and pop: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; in_data[0] = 32'hA0 + i;
      tick();
    end
    check("t4_count_before", o_count[0], 3);
    in_data[0] = 32'hA3; out_ready[0] = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    check("t4_count", o_count[0], 0);
    check("t4_valid", o_valid[0], 0);
    check("t4_ae", o_ae[0], 1);

    if (PKT) begin
      // Packet of 4 words: held back until the TLAST word is stored.
      for (int i = 0; i < 4; i++) begin
        in_valid[0] = 1'b1; in_data[0] = 32'hB0 + i; in_last[0] = (i == 3);
        tick();
        check($sformatf("t5_valid_%0d", i), o_valid[0], i == 3);
      end
      in_valid[0] = 1'b0; in_last[0] = 1'b0; out_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t5_data_%0d", i), o_data[0], 32'hB0 + i);
        check($sformatf("t5_last_%0d", i), o_last[0], i == 3);
        tick();
      end
      out_ready[0] = 1'b0;
      check("t5_empty", o_valid[0], 0);

      // DEPTH 8 with a 10-word packet lacking TLAST: released once full.
      for (int i = 0; i < 8; i++) begin
        in_valid[2] = 1'b1; in_data[2] = 32'hC0 + i;
        tick();
        check($sformatf("t6_valid_%0d", i), o_valid[2], i == 7);
      end
      nin = 8; nout = 0; out_ready[2] = 1'b1;
      for (cyc = 0; cyc < 100 && nout < 10; cyc++) begin
        automatic bit acc_in;
        in_valid[2] = (nin < 10);
        in_data[2] = 32'hC0 + nin;
        acc_in = in_valid[2] && o_ready[2];
        if (o_valid[2]) begin
          check("t6_order", o_data[2], 32'hC0 + nout);
          nout++;
        end
        tick();
        if (acc_in) nin++;
      end
      in_valid[2] = 1'b0; out_ready[2] = 1'b0;
      check("t6_all_out", nout, 10);
    end

    // Asynchronous reset while holding data.
    in_valid[0] = 1'b1; in_data[0] = 32'hD0;
    tick();
    tick();
    in_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("t7_async_count", o_count[0], 0);
    check("t7_async_valid", o_valid[0], 0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
